multi_cache_arbiter: RTL
========================

# multi_cache_arbiter

Parametrised N-channel cache-to-memory arbiter with a coordinated flush sequencer. It sits between N L1/pass-through caches (I$, D$, and any further caches) and the single memory-side generic bus. It arbitrates their memory requests round-robin or by fixed priority. On a halt flush it steps through the flushable caches one at a time and reports aggregate completion.

## Interface
Parameters:
- NUM_CH, 2, number of cache channels (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)
- FLUSH_MASK, all ones (NUM_CH bits), bit i = 1 means channel i takes part in the flush sequence

Ports:
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  asynchronous active-low reset
- req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  per-channel write data
- req_byte_en  in  NUM_CH*DATA_W/8  per-channel byte enables
- req_ren, req_wen  in  NUM_CH each  per-channel read/write request
- req_rdata  out  DATA_W  read data, broadcast to all channels
- req_busy  out  NUM_CH  per-channel busy; low only for the granted channel on completion
- mem_addr, mem_wdata, mem_byte_en, mem_ren, mem_wen  out  ADDR_W/DATA_W/DATA_W/8/1/1  memory-side request
- mem_rdata  in  DATA_W  memory read data
- mem_busy  in  1  memory busy; low = transfer completes this cycle
- flush_req  in  1  level request to flush all masked caches
- cache_flush  out  NUM_CH  per-cache flush command
- cache_flush_done  in  NUM_CH  per-cache flush completion
- flush_done  out  1  all masked caches flushed

## Operation
- Bus FSM states: ARB_IDLE and ARB_BUSY. Registers: grant index g and last-grant pointer lg.
- ARB_IDLE: a channel is requesting if req_ren[i] | req_wen[i]. If any channel is requesting, pick the winner, register g, and go to ARB_BUSY.
  - Round-robin winner: first requester searching lg+1, lg+2, … modulo NUM_CH.
  - Fixed-priority winner: lowest requesting index.
- ARB_BUSY drive rules:
  - mem_* outputs equal channel g's request signals.
  - req_rdata = mem_rdata.
  - req_busy[g] = mem_busy. All other req_busy bits = 1.
- Leaving ARB_BUSY:
  - mem_busy = 0: go to ARB_IDLE and set lg = g.
  - Channel g drops both ren and wen (abort): go to ARB_IDLE; lg is not updated.
- In ARB_IDLE, mem_ren = mem_wen = 0, all req_busy = 1, and mem_addr/mem_wdata/mem_byte_en = 0.
- ren and wen both high on the winner: pass both through unchanged. Legality is the caches' responsibility.
- Flush FSM states: F_IDLE, F_CH, F_DONE. Register fc holds the current channel.
  - F_IDLE with flush_req = 1: set fc to the lowest masked index and enter F_CH. If FLUSH_MASK = 0, enter F_DONE directly.
  - F_CH: cache_flush[fc] = 1; all other bits are 0. When cache_flush_done[fc] = 1, advance fc to the next higher masked index, or enter F_DONE after the last one.
  - F_CH, flush_req drops: the current channel still runs until its done is seen, then the FSM goes to F_IDLE. flush_done is never asserted on that path.
  - F_DONE: flush_done = 1. The FSM stays until flush_req = 0, then goes to F_IDLE.
- The bus and flush FSMs are independent. Arbitration continues during a flush so that flushing caches can write back.

## Timing
- Reset values:
  - Both FSMs idle; lg = NUM_CH-1, so channel 0 wins the first round-robin.
  - g = 0, fc = 0.
  - mem_ren = mem_wen = 0; mem_addr, mem_wdata, mem_byte_en = 0.
  - req_busy all 1; req_rdata = 0 while idle.
  - cache_flush = 0, flush_done = 0.
- Reset asserted mid-transfer or mid-flush: every output returns to its reset value immediately (asynchronous).
- Grant latency: a request seen at edge k drives mem_* from cycle k+1. With zero-wait memory, req_busy[g] = 0 in cycle k+1 and the arbiter is back in ARB_IDLE at edge k+2.
- Back-to-back: the minimum transaction spacing per arbiter is 2 cycles (one ARB_IDLE cycle between grants).
- req_busy and req_rdata are combinational from mem_busy and mem_rdata in ARB_BUSY.
- Flush: cache_flush[i] rises the cycle after F_CH(i) is entered. It falls the cycle after cache_flush_done[i] is sampled high. The next channel's flush rises in that same cycle.
- flush_done rises one cycle after the last done is sampled. It falls one cycle after flush_req = 0 is sampled.

## Test plan
- Reset/idle: hold nRST low, then release with no requests. Required: mem_ren = mem_wen = 0, req_busy = 2'b11, cache_flush = 0, flush_done = 0.
- Round-robin contention (NUM_CH = 2, PRIO_MODE = 0): both channels read continuously with zero-wait memory. Required grant order is ch0, ch1, ch0, ch1. mem_addr alternates between 0x100 (ch0) and 0x200 (ch1), and each req_busy bit goes low once per 4 cycles.
- Fixed priority (PRIO_MODE = 1): both channels request continuously. Required: ch1 is never granted while ch0 requests.
- Wait states plus abort:
  - ch1 writes 0xDEADBEEF with mem_busy held high for 3 cycles. Required: mem_wdata is stable for all 3 cycles and req_busy[1] falls in the 4th.
  - Repeat with ch1 dropping wen in cycle 2. Required: mem_wen = 0 the next cycle and lg is unchanged.
- Flush sequence (FLUSH_MASK = 2'b10, then 2'b11): pulse flush_req high and hold it.
  - With mask 2'b10: only cache_flush[1] asserts, and flush_done rises one cycle after cache_flush_done[1].
  - With mask 2'b11: cache_flush[0] and then cache_flush[1] assert, never overlapping.
  - Meanwhile, ch0 write-backs are granted throughout.
- Flush abort plus reset: drop flush_req during F_CH(0). Required: cache_flush[0] is held until done, then the FSM goes to F_IDLE with no flush_done. Then assert nRST mid-transfer. Required: all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/multi_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : multi_cache_arbiter
// Description : N-channel cache-to-memory bus arbiter (round-robin or fixed
//               priority) with a sequential per-cache flush coordinator.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cache_arbiter #(
    parameter int                NUM_CH     = 2,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                PRIO_MODE  = 0,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = '1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_byte_en,
    input  logic [NUM_CH-1:0]          req_ren,
    input  logic [NUM_CH-1:0]          req_wen,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [NUM_CH-1:0]          req_busy,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_byte_en,
    output logic                       mem_ren,
    output logic                       mem_wen,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_busy,
    input  logic                       flush_req,
    output logic [NUM_CH-1:0]          cache_flush,
    input  logic [NUM_CH-1:0]          cache_flush_done,
    output logic                       flush_done
);
    localparam int BE_W = DATA_W / 8;
    localparam int GW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;
    typedef enum logic [1:0] {F_IDLE = 2'd0, F_CH = 2'd1, F_DONE = 2'd2} flush_state_t;

    arb_state_t        r_arb_st, w_arb_nx;
    logic [GW-1:0]     r_g, w_g_nx;
    logic [GW-1:0]     r_lg, w_lg_nx;
    logic [NUM_CH-1:0] w_reqs;
    logic [GW-1:0]     w_win;
    logic [GW-1:0]     w_rr_idx;
    logic [ADDR_W-1:0] w_g_addr;
    logic [DATA_W-1:0] w_g_wdata;
    logic [BE_W-1:0]   w_g_be;
    logic              w_g_ren;
    logic              w_g_wen;

    flush_state_t      r_f_st, w_f_nx;
    logic [GW-1:0]     r_fc, w_fc_nx;
    logic              r_fab, w_fab_nx;
    logic              w_first_ok, w_next_ok, w_fc_done;
    logic [GW-1:0]     w_first, w_next;

    assign w_reqs = req_ren | req_wen;

    // Winner selection: rotating search after the last grant, or lowest index
    always_comb begin
        w_win    = '0;
        w_rr_idx = '0;
        if (PRIO_MODE != 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (w_reqs[i]) w_win = GW'(i);
            end
        end else begin
            // Descending scan so the nearest requester after r_lg wins last
            for (int k = NUM_CH; k >= 1; k--) begin
                w_rr_idx = GW'((int'(r_lg) + k) % NUM_CH);
                if (w_reqs[w_rr_idx]) w_win = w_rr_idx;
            end
        end
    end

    // Select the request fields of the currently granted channel
    always_comb begin
        w_g_addr  = '0;
        w_g_wdata = '0;
        w_g_be    = '0;
        w_g_ren   = 1'b0;
        w_g_wen   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_g == GW'(i)) begin
                w_g_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_g_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_g_be    = req_byte_en[i*BE_W +: BE_W];
                w_g_ren   = req_ren[i];
                w_g_wen   = req_wen[i];
            end
        end
    end

    // Bus arbiter state, grant and last-grant registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_arb_st <= ARB_IDLE;
            r_g      <= '0;
            r_lg     <= GW'(NUM_CH - 1);
        end else begin
            r_arb_st <= w_arb_nx;
            r_g      <= w_g_nx;
            r_lg     <= w_lg_nx;
        end
    end

    // Bus next-state and memory/cache-side outputs
    always_comb begin
        w_arb_nx    = r_arb_st;
        w_g_nx      = r_g;
        w_lg_nx     = r_lg;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_byte_en = '0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        req_rdata   = '0;
        req_busy    = '1;
        case (r_arb_st)
            ARB_IDLE: begin
                if (|w_reqs) begin
                    w_g_nx   = w_win;
                    w_arb_nx = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                mem_addr    = w_g_addr;
                mem_wdata   = w_g_wdata;
                mem_byte_en = w_g_be;
                mem_ren     = w_g_ren;
                mem_wen     = w_g_wen;
                req_rdata   = mem_rdata;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_g == GW'(i)) req_busy[i] = mem_busy;
                end
                // Completion takes precedence; an abort leaves fairness untouched
                if (!mem_busy) begin
                    w_arb_nx = ARB_IDLE;
                    w_lg_nx  = r_g;
                end else if (!(w_g_ren || w_g_wen)) begin
                    w_arb_nx = ARB_IDLE;
                end
            end
            default: w_arb_nx = ARB_IDLE;
        endcase
    end

    // First masked channel, next masked channel above fc, and fc's done flag
    always_comb begin
        w_first_ok = 1'b0;
        w_first    = '0;
        w_next_ok  = 1'b0;
        w_next     = '0;
        w_fc_done  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (FLUSH_MASK[i]) begin
                w_first_ok = 1'b1;
                w_first    = GW'(i);
                if (GW'(i) > r_fc) begin
                    w_next_ok = 1'b1;
                    w_next    = GW'(i);
                end
            end
            if (r_fc == GW'(i)) w_fc_done = cache_flush_done[i];
        end
    end

    // Flush sequencer state, current channel and sticky abort flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_f_st <= F_IDLE;
            r_fc   <= '0;
            r_fab  <= 1'b0;
        end else begin
            r_f_st <= w_f_nx;
            r_fc   <= w_fc_nx;
            r_fab  <= w_fab_nx;
        end
    end

    // Flush next-state and flush command/completion outputs
    always_comb begin
        w_f_nx      = r_f_st;
        w_fc_nx     = r_fc;
        w_fab_nx    = r_fab;
        cache_flush = '0;
        flush_done  = 1'b0;
        case (r_f_st)
            F_IDLE: begin
                w_fab_nx = 1'b0;
                if (flush_req) begin
                    if (w_first_ok) begin
                        w_fc_nx = w_first;
                        w_f_nx  = F_CH;
                    end else begin
                        w_f_nx  = F_DONE;
                    end
                end
            end
            F_CH: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_fc == GW'(i)) cache_flush[i] = 1'b1;
                end
                // A withdrawn request lets the running cache finish, then stops
                if (!flush_req) w_fab_nx = 1'b1;
                if (w_fc_done) begin
                    if (r_fab || !flush_req) begin
                        w_f_nx   = F_IDLE;
                        w_fab_nx = 1'b0;
                    end else if (w_next_ok) begin
                        w_fc_nx  = w_next;
                    end else begin
                        w_f_nx   = F_DONE;
                    end
                end
            end
            F_DONE: begin
                flush_done = 1'b1;
                if (!flush_req) w_f_nx = F_IDLE;
            end
            default: w_f_nx = F_IDLE;
        endcase
    end

endmodule
`default_nettype wire
